sync_fifo_param: RTL and testbench

Single-clock, parametrised FIFO: the same-domain successor to the team's dual-clock FIFO, for buffering within one clock domain. It generalises width, depth and thresholds and adds programmable almost-full/almost-empty flags, a fill-level count, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer pipeline stages sharing one clock.

---
 rtl/sync_fifo_param.sv | 126 ++++++++++++
 tb/tb_sync_fifo_param.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with programmable almost-full/almost-empty flags,
// fill level, synchronous flush and selectable standard / first-word-fall-through read.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH          = 16,
    parameter int unsigned FIFO_DEPTH          = 32,
    parameter int unsigned ALMOST_FULL_THRESH  = 28,
    parameter int unsigned ALMOST_EMPTY_THRESH = 4,
    parameter bit          FWFT                = 1'b0,
    localparam int unsigned ADDR_SIZE          = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_enable,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_SIZE:0]    fill_level,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow
);

    localparam int unsigned CNT_W = ADDR_SIZE + 1;

    // Reject illegal configurations at elaboration.
    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: FIFO_DEPTH must be a power of two and at least 4");
    end
    if ((ALMOST_EMPTY_THRESH < 1) || (ALMOST_EMPTY_THRESH >= ALMOST_FULL_THRESH) ||
        (ALMOST_FULL_THRESH >= FIFO_DEPTH)) begin : g_bad_thresh
        $error("sync_fifo_param: need 1 <= ALMOST_EMPTY_THRESH < ALMOST_FULL_THRESH < FIFO_DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_SIZE-1:0]  wr_ptr;
    logic [ADDR_SIZE-1:0]  rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  rd_ok;
    logic                  wr_ok;

    // Status flags are pure compares on count.
    assign fill_level   = count;
    assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty   = (count == '0);
    assign almost_full  = (count >= CNT_W'(ALMOST_FULL_THRESH));
    assign almost_empty = (count <= CNT_W'(ALMOST_EMPTY_THRESH));

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign rd_ok = read_enable & ~fifo_empty;
    assign wr_ok = write_enable & (~fifo_full | rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok && !flush) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_SIZE'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_SIZE'(1);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CNT_W'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Rejected-request pulses, suppressed during flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else if (flush) begin
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else begin
            fifo_overflow  <= write_enable & ~wr_ok;
            fifo_underflow <= read_enable & ~rd_ok;
        end
    end

    if (FWFT) begin : g_fwft
        assign data_out   = mem[rd_ptr];
        assign data_valid = ~fifo_empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  dvalid_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dout_q   <= '0;
                dvalid_q <= 1'b0;
            end else if (flush) begin
                dvalid_q <= 1'b0;
            end else if (rd_ok) begin
                dout_q   <= mem[rd_ptr];
                dvalid_q <= 1'b1;
            end else begin
                dvalid_q <= 1'b0;
            end
        end

        assign data_out   = dout_q;
        assign data_valid = dvalid_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-mode instance driven against a queue
// scoreboard, and a first-word-fall-through instance with its own short scenario.
module tb_sync_fifo_param;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic          s_we, s_re, s_flush;
    logic [DW-1:0] s_din, s_dout;
    logic          s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [AW:0]   s_fill;

    logic          f_we, f_re, f_flush;
    logic [DW-1:0] f_din, f_dout;
    logic          f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [AW:0]   f_fill;

    sync_fifo_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ALMOST_FULL_THRESH(28),
                      .ALMOST_EMPTY_THRESH(4), .FWFT(1'b0)) u_std (
        .clk(clk), .reset_n(reset_n), .write_enable(s_we), .data_in(s_din),
        .read_enable(s_re), .flush(s_flush), .data_out(s_dout), .data_valid(s_dv),
        .fifo_full(s_full), .fifo_empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .fill_level(s_fill), .fifo_overflow(s_ovf),
        .fifo_underflow(s_unf));

    sync_fifo_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ALMOST_FULL_THRESH(28),
                      .ALMOST_EMPTY_THRESH(4), .FWFT(1'b1)) u_fwft (
        .clk(clk), .reset_n(reset_n), .write_enable(f_we), .data_in(f_din),
        .read_enable(f_re), .flush(f_flush), .data_out(f_dout), .data_valid(f_dv),
        .fifo_full(f_full), .fifo_empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .fill_level(f_fill), .fifo_overflow(f_ovf),
        .fifo_underflow(f_unf));

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] sb[$];
    int            mcount;
    logic [DW-1:0] exp_data;

    // One clock of stimulus on the standard instance; the model decides acceptance,
    // pushes accepted writes and pops the word an accepted read must return.
    task automatic step(input logic we, input logic [DW-1:0] d, input logic re, input logic fl);
        logic rd_ok, wr_ok;
        rd_ok = re && (mcount != 0);
        wr_ok = we && ((mcount != DEPTH) || rd_ok);
        s_we = we; s_din = d; s_re = re; s_flush = fl;
        if (fl) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (rd_ok) exp_data = sb.pop_front();
            if (wr_ok) sb.push_back(d);
            mcount = mcount + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
        end
        @(posedge clk);
        #1;
        s_we = 1'b0; s_re = 1'b0; s_flush = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        s_we = 0; s_re = 0; s_flush = 0; s_din = '0;
        f_we = 0; f_re = 0; f_flush = 0; f_din = '0;
        mcount = 0; exp_data = '0;
        #1;
        n_checks++;
        if ({s_fill, s_empty, s_ae, s_full, s_af, s_dv, s_dout, s_ovf, s_unf} !==
            {6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_std: fill=%0d empty=%b ae=%b full=%b af=%b dv=%b dout=%h ovf=%b unf=%b, want 0 1 1 0 0 0 0000 0 0",
                     s_fill, s_empty, s_ae, s_full, s_af, s_dv, s_dout, s_ovf, s_unf);
        end
        n_checks++;
        if ({f_fill, f_empty, f_dv} !== {6'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_fwft: fill=%0d empty=%b dv=%b, want 0 1 0", f_fill, f_empty, f_dv);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 32; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
            n_checks++;
            if ({s_fill, s_full, s_af, s_ae, s_empty} !== {6'(i), (i == 32), (i >= 28), (i <= 4), 1'b0}) begin
                n_fail++;
                $display("FAIL fill_flags after write %0d: fill=%0d full=%b af=%b ae=%b empty=%b, want fill=%0d",
                         i, s_fill, s_full, s_af, s_ae, s_empty, i);
            end
        end
        step(1'b1, 16'h0021, 1'b0, 1'b0);
        n_checks++;
        if ({s_ovf, s_fill} !== {1'b1, 6'd32}) begin
            n_fail++;
            $display("FAIL overflow_pulse: ovf=%b fill=%0d, want 1 32", s_ovf, s_fill);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (s_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_one_cycle: ovf=%b, want 0", s_ovf);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 32; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if ({s_dv, s_dout, s_fill} !== {1'b1, exp_data, 6'(32 - i)} || s_dout !== DW'(i)) begin
                n_fail++;
                $display("FAIL drain_read %0d: dv=%b dout=%h fill=%0d, want 1 %h %0d",
                         i, s_dv, s_dout, s_fill, exp_data, 32 - i);
            end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if ({s_unf, s_dv, s_dout, s_empty} !== {1'b1, 1'b0, 16'h0020, 1'b1}) begin
            n_fail++;
            $display("FAIL underflow_pulse: unf=%b dv=%b dout=%h empty=%b, want 1 0 0020 1",
                     s_unf, s_dv, s_dout, s_empty);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (s_unf !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_one_cycle: unf=%b, want 0", s_unf);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 32; i++) step(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
        step(1'b1, 16'h0200, 1'b1, 1'b0);
        n_checks++;
        if ({s_fill, s_ovf, s_dv, s_dout} !== {6'd32, 1'b0, 1'b1, 16'h0100}) begin
            n_fail++;
            $display("FAIL rw_at_full: fill=%0d ovf=%b dv=%b dout=%h, want 32 0 1 0100",
                     s_fill, s_ovf, s_dv, s_dout);
        end
        for (int i = 0; i < 32; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if ({s_dv, s_dout} !== {1'b1, exp_data}) begin
                n_fail++;
                $display("FAIL rw_drain %0d: dv=%b dout=%h, want 1 %h", i, s_dv, s_dout, exp_data);
            end
        end
        step(1'b1, 16'h0300, 1'b1, 1'b0);
        n_checks++;
        if ({s_fill, s_unf, s_dv} !== {6'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rw_at_empty: fill=%0d unf=%b dv=%b, want 1 1 0", s_fill, s_unf, s_dv);
        end
        for (int k = 0; k < 100; k++) begin
            step(1'b1, DW'(16'h0400 + k), 1'b1, 1'b0);
            n_checks++;
            if ({s_dv, s_dout, s_fill, s_ovf, s_unf} !== {1'b1, exp_data, 6'd1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL stream %0d: dv=%b dout=%h fill=%0d ovf=%b unf=%b, want 1 %h 1 0 0",
                         k, s_dv, s_dout, s_fill, s_ovf, s_unf, exp_data);
            end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if ({s_dv, s_dout, s_empty} !== {1'b1, 16'h0463, 1'b1}) begin
            n_fail++;
            $display("FAIL stream_tail: dv=%b dout=%h empty=%b, want 1 0463 1", s_dv, s_dout, s_empty);
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] held;
        for (int i = 0; i < 10; i++) step(1'b1, DW'(16'h0500 + i), 1'b0, 1'b0);
        held = s_dout;
        step(1'b1, 16'hBEEF, 1'b0, 1'b1);
        n_checks++;
        if ({s_fill, s_empty, s_dv, s_ovf, s_dout} !== {6'd0, 1'b1, 1'b0, 1'b0, held}) begin
            n_fail++;
            $display("FAIL flush: fill=%0d empty=%b dv=%b ovf=%b dout=%h, want 0 1 0 0 %h",
                     s_fill, s_empty, s_dv, s_ovf, s_dout, held);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (s_unf !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_masks_underflow: unf=%b, want 0", s_unf);
        end
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if ({s_dv, s_dout, s_empty} !== {1'b1, exp_data, 1'b1} || s_dout !== 16'h1234) begin
            n_fail++;
            $display("FAIL post_flush_read: dv=%b dout=%h empty=%b, want 1 1234 1", s_dv, s_dout, s_empty);
        end
    endtask

    task automatic test_fwft();
        logic [DW-1:0] fq[$];
        f_we = 1'b1; f_din = 16'hA5A5;
        @(posedge clk); #1;
        f_we = 1'b0;
        n_checks++;
        if ({f_dv, f_dout, f_fill} !== {1'b1, 16'hA5A5, 6'd1}) begin
            n_fail++;
            $display("FAIL fwft_visible: dv=%b dout=%h fill=%0d, want 1 a5a5 1", f_dv, f_dout, f_fill);
        end
        f_re = 1'b1;
        @(posedge clk); #1;
        f_re = 1'b0;
        n_checks++;
        if ({f_dv, f_empty} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL fwft_pop: dv=%b empty=%b, want 0 1", f_dv, f_empty);
        end
        for (int k = 1; k <= 3; k++) begin
            f_we = 1'b1; f_din = DW'(16'h0011 * k);
            fq.push_back(f_din);
            @(posedge clk); #1;
        end
        f_we = 1'b0;
        f_re = 1'b1;
        while (fq.size() != 0) begin
            n_checks++;
            if ({f_dv, f_dout} !== {1'b1, fq[0]}) begin
                n_fail++;
                $display("FAIL fwft_stream: dv=%b dout=%h, want 1 %h", f_dv, f_dout, fq[0]);
            end
            @(posedge clk); #1;
            void'(fq.pop_front());
        end
        f_re = 1'b0;
        n_checks++;
        if ({f_dv, f_empty} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL fwft_drained: dv=%b empty=%b, want 0 1", f_dv, f_empty);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 32; i++) step(1'b1, DW'(16'h0600 + i), 1'b0, 1'b0);
        s_re = 1'b1;
        @(posedge clk); #1;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({s_fill, s_empty, s_ae, s_full, s_af, s_dv, s_dout, s_ovf, s_unf} !==
            {6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: fill=%0d empty=%b ae=%b full=%b af=%b dv=%b dout=%h ovf=%b unf=%b, want 0 1 1 0 0 0 0000 0 0",
                     s_fill, s_empty, s_ae, s_full, s_af, s_dv, s_dout, s_ovf, s_unf);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({s_fill, s_dv} !== {6'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_held: fill=%0d dv=%b, want 0 0", s_fill, s_dv);
        end
        s_re = 1'b0;
        reset_n = 1'b1;
        sb.delete();
        mcount = 0;
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if ({s_unf, s_dv, s_empty} !== {1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset_empty: unf=%b dv=%b empty=%b, want 1 0 1", s_unf, s_dv, s_empty);
        end
        step(1'b1, 16'h0077, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if ({s_dv, s_dout} !== {1'b1, exp_data} || s_dout !== 16'h0077) begin
            n_fail++;
            $display("FAIL post_reset_rw: dv=%b dout=%h, want 1 0077", s_dv, s_dout);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_flush();
        test_fwft();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
